// File: rtl/line_mem_ctrl_if.sv
// Line-memory types and the request/response bus between a core data port and line_mem_ctrl.
package Mem;
  localparam int LINE_W = 64;
  localparam int ADDR_W = 32;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] lineaddr_t;
endpackage

interface line_mem_ctrl_if;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_id;
  logic           req_we;
  Mem::lineaddr_t req_addr;
  Mem::line_t     req_data;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  Mem::line_t     resp_data;

  modport master (
    output req_valid, req_id, req_we, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );
  modport slave (
    input  req_valid, req_id, req_we, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory: fixed-latency pipeline into an in-order response queue,
// with credit-based request acceptance so the queue can never overflow.
module line_mem_ctrl #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4,
  parameter int RESPQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  line_mem_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(RESPQ_DEPTH + 1);
  localparam int PTR_W = $clog2(RESPQ_DEPTH);

  Mem::line_t mem [DEPTH_LINES];

  logic             live;
  logic [CNT_W-1:0] outstanding;
  logic             fire;
  logic [IDX_W-1:0] idx;
  Mem::line_t       cap_data;
  logic             push;
  logic [1:0]       push_id;
  Mem::line_t       push_data;
  logic             pop;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] q_cnt;
  logic [1:0]       q_id   [RESPQ_DEPTH];
  Mem::line_t       q_data [RESPQ_DEPTH];
  logic             addr_unused;

  assign idx         = bus.req_addr[IDX_W-1:0];
  assign addr_unused = ^bus.req_addr[Mem::ADDR_W-1:IDX_W];

  // live holds req_ready low while reset is applied and releases it on the first clock after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign bus.req_ready = live && (outstanding < CNT_W'(RESPQ_DEPTH));
  assign fire          = bus.req_valid && bus.req_ready;
  assign cap_data      = bus.req_we ? bus.req_data : mem[idx];

  always_ff @(posedge clk) begin
    if (fire && bus.req_we) mem[idx] <= bus.req_data;
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] pv;
      logic [1:0]         pid  [LATENCY-1];
      Mem::line_t         pdat [LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
        end else begin
          pv[0] <= fire;
          for (int k = 1; k < LATENCY - 1; k++) pv[k] <= pv[k-1];
        end
      end

      always_ff @(posedge clk) begin
        pid[0]  <= bus.req_id;
        pdat[0] <= cap_data;
        for (int k = 1; k < LATENCY - 1; k++) begin
          pid[k]  <= pid[k-1];
          pdat[k] <= pdat[k-1];
        end
      end

      assign push      = pv[LATENCY-2];
      assign push_id   = pid[LATENCY-2];
      assign push_data = pdat[LATENCY-2];
    end else begin : g_nopipe
      assign push      = fire;
      assign push_id   = bus.req_id;
      assign push_data = cap_data;
    end
  endgenerate

  assign empty          = (q_cnt == '0);
  assign pop            = !empty && bus.resp_ready;
  assign bus.resp_valid = !empty;
  assign bus.resp_id    = empty ? 2'b00 : q_id[rd_ptr];
  assign bus.resp_data  = empty ? '0 : q_data[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_cnt       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_cnt       <= q_cnt + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]   <= push_id;
      q_data[wr_ptr] <= push_data;
    end
  end

  // Credits cover pipeline plus queue, so neither of these can fire in a correct design.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && q_cnt == CNT_W'(RESPQ_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && outstanding == '0));
endmodule
